// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryption sequencer: loads a plaintext/key pair, steps an
// external round / key-expansion datapath through NR rounds, then holds the ciphertext.
module aes128_iter_ctrl #(
  parameter int unsigned NR  = 10,
  parameter int unsigned RCW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_pt,
  input  logic [127:0]   in_key,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_ct,
  output logic           busy,
  output logic [RCW-1:0] rc_o,
  output logic [127:0]   data_o,
  output logic [127:0]   key_o,
  input  logic [127:0]   keyout_i,
  input  logic [127:0]   rndout_i,
  input  logic [127:0]   lastout_i
);

  localparam int unsigned BW = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [BW-1:0]  st_q, st_d;
  logic [BW-1:0]  key_q, key_d;
  logic [RCW-1:0] rc_q, rc_d;
  logic           load;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      key_q   <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
    end
  end

  // A new pair is taken in IDLE, or in DONE on the same edge the ciphertext leaves
  assign load = in_valid && in_ready;

  // Next-state and register update logic
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    rc_d    = rc_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          st_d    = in_pt ^ in_key;
          key_d   = in_key;
          rc_d    = RCW'(1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        key_d = keyout_i;
        if (rc_q >= RCW'(NR)) begin
          st_d    = lastout_i;
          rc_d    = '0;
          state_d = DONE;
        end else begin
          st_d = rndout_i;
          rc_d = rc_q + RCW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          if (load) begin
            st_d    = in_pt ^ in_key;
            key_d   = in_key;
            rc_d    = RCW'(1);
            state_d = ROUND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        rc_d    = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      ROUND:   busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready  = 1'b0;
    endcase
    out_ct = st_q;
    data_o = st_q;
    key_o  = key_q;
    rc_o   = rc_q;
  end

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Bench for aes128_iter_ctrl: behavioural AES round datapath around the DUT, known-answer
// vectors, handshake corner sequences and randomized traffic against a block-level model.
module tb_aes128_iter_ctrl;

  localparam int NR  = 10;
  localparam int RCW = 4;

  typedef logic [127:0] blk_t;
  typedef blk_t rk_t [0:10];
  typedef struct {
    blk_t pt;
    blk_t key;
    blk_t ct;
    int   lat;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, out_valid, out_ready, busy;
  blk_t           in_pt, in_key, out_ct, data_o, key_o;
  blk_t           keyout, rndout, lastout;
  logic [RCW-1:0] rc_o;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  blk_t got_q[$];
  int   got_cyc_q[$];

  // Block-level model: one block either in flight or waiting, with cycles since accept
  bit   m_pend = 1'b0;
  int   m_cnt  = 0;
  blk_t m_ct;
  rk_t  m_rk;

  always #5 clk = ~clk;

  aes128_iter_ctrl #(.NR(NR), .RCW(RCW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pt     (in_pt),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ct    (out_ct),
    .busy      (busy),
    .rc_o      (rc_o),
    .data_o    (data_o),
    .key_o     (key_o),
    .keyout_i  (keyout),
    .rndout_i  (rndout),
    .lastout_i (lastout)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic blk_t sub_bytes(input blk_t s);
    blk_t r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  function automatic blk_t shift_rows(input blk_t s);
    blk_t r;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[127-8*(rw+4*c) -: 8] = s[127-8*(rw+4*((c+rw)%4)) -: 8];
    return r;
  endfunction

  function automatic blk_t mix_cols(input blk_t s);
    blk_t r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return r;
  endfunction

  function automatic blk_t key_round(input blk_t k, input logic [RCW-1:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rcon;
    {w0, w1, w2, w3} = k;
    rcon = 8'h01;
    for (int i = 1; i < int'(rc); i++) rcon = xt(rcon);
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Full-block reference: word-wise key schedule and straight-line encryption
  function automatic void aes_ref(input blk_t pt, input blk_t key, output blk_t ct, output rk_t rk);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    blk_t        s;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t    = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    s = pt ^ rk[0];
    for (int r = 1; r < 10; r++) s = mix_cols(shift_rows(sub_bytes(s))) ^ rk[r];
    ct = shift_rows(sub_bytes(s)) ^ rk[10];
  endfunction

  assign keyout  = key_round(key_o, rc_o);
  assign rndout  = mix_cols(shift_rows(sub_bytes(data_o))) ^ keyout;
  assign lastout = shift_rows(sub_bytes(data_o)) ^ keyout;

  task automatic chk(input string name, input blk_t got, input blk_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock: check outputs against the model, then advance the model across the edge
  task automatic tick();
    logic           e_busy, e_ov, e_ir, acc;
    logic [RCW-1:0] e_rc;
    blk_t           a_pt, a_key;
    #1;
    e_busy = m_pend && (m_cnt < NR);
    e_ov   = m_pend && (m_cnt >= NR);
    e_rc   = e_busy ? RCW'(m_cnt + 1) : '0;
    e_ir   = !m_pend || (e_ov && out_ready);
    chk("busy",      128'(busy),      128'(e_busy));
    chk("out_valid", 128'(out_valid), 128'(e_ov));
    chk("in_ready",  128'(in_ready),  128'(e_ir));
    chk("rc_o",      128'(rc_o),      128'(e_rc));
    if (e_ov)   chk("out_ct", out_ct, m_ct);
    if (e_busy) chk("key_o", key_o, m_rk[m_cnt]);
    acc   = !rst && in_valid && e_ir;
    a_pt  = in_pt;
    a_key = in_key;
    if (!rst && e_ov && out_ready) begin
      got_q.push_back(out_ct);
      got_cyc_q.push_back(cyc);
    end
    @(negedge clk);
    if (rst) begin
      m_pend = 1'b0;
      m_cnt  = 0;
    end else begin
      if (m_pend && m_cnt < NR) m_cnt++;
      else if (e_ov && out_ready) m_pend = 1'b0;
      if (acc) begin
        m_pend = 1'b1;
        m_cnt  = 0;
        aes_ref(a_pt, a_key, m_ct, m_rk);
      end
    end
    cyc++;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt [0:2];
    int   n, t0;
    vt[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 11};
    vt[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3925841d02dc09fbdc118597196a0b32, 11};
    vt[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 11};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pt = '0; in_key = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_rc_o",      128'(rc_o),      128'(0));
    chk("rst_out_ct",    out_ct, '0);
    chk("rst_data_o",    data_o, '0);
    chk("rst_key_o",     key_o,  '0);

    // Idle stability
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_out_ct", out_ct, '0);
    end

    // Known-answer vectors with out_ready held high
    for (int v = 0; v < 3; v++) begin
      got_q.delete(); got_cyc_q.delete();
      in_pt = vt[v].pt; in_key = vt[v].key; in_valid = 1'b1; out_ready = 1'b1;
      t0 = cyc;
      tick();
      in_valid = 1'b0; in_pt = '1; in_key = '1;
      n = 0;
      while (got_q.size() == 0 && n < 30) begin
        if (v == 1 && rc_o == RCW'(1)) chk("kat_key_rc1", key_o, vt[v].key);
        if (v == 1 && rc_o == RCW'(2)) chk("kat_key_rc2", key_o, 128'ha0fafe1788542cb123a339392a6c7605);
        tick();
        n++;
      end
      chk("kat_out_count", 128'(got_q.size()), 128'(1));
      if (got_q.size() > 0) begin
        chk("kat_ct",      got_q[0], vt[v].ct);
        chk("kat_latency", 128'(got_cyc_q[0] - t0), 128'(vt[v].lat));
      end
    end

    // Backpressure: held ciphertext, foreign input pulses ignored, single acceptance
    got_q.delete(); got_cyc_q.delete();
    in_pt = vt[0].pt; in_key = vt[0].key; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin tick(); n++; end
    chk("bp_valid", 128'(out_valid), 128'(1));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'(i % 2 == 0);
      in_pt  = {$urandom, $urandom, $urandom, $urandom};
      in_key = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk("bp_hold_ct", out_ct, vt[0].ct);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    chk("bp_single", 128'(got_q.size()), 128'(1));
    if (got_q.size() > 0) chk("bp_ct", got_q[0], vt[0].ct);

    // Back-to-back: second block loads on the edge the first leaves
    got_q.delete(); got_cyc_q.delete();
    in_pt = vt[0].pt; in_key = vt[0].key; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_pt = vt[1].pt; in_key = vt[1].key;
    n = 0;
    while (got_q.size() < 1 && n < 30) begin tick(); n++; end
    in_valid = 1'b0;
    n = 0;
    while (got_q.size() < 2 && n < 30) begin tick(); n++; end
    chk("b2b_count", 128'(got_q.size()), 128'(2));
    if (got_q.size() >= 2) begin
      chk("b2b_ct0", got_q[0], vt[0].ct);
      chk("b2b_ct1", got_q[1], vt[1].ct);
      chk("b2b_gap", 128'(got_cyc_q[1] - got_cyc_q[0]), 128'(NR + 1));
    end

    // Reset in the middle of a block
    got_q.delete(); got_cyc_q.delete();
    in_pt = vt[0].pt; in_key = vt[0].key; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (rc_o != RCW'(5) && n < 30) begin tick(); n++; end
    chk("mid_rc5", 128'(rc_o), 128'(5));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_out_valid", 128'(out_valid), 128'(0));
    chk("mid_busy",      128'(busy),      128'(0));
    chk("mid_in_ready",  128'(in_ready),  128'(1));
    chk("mid_rc_o",      128'(rc_o),      128'(0));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 13; i++) tick();
    chk("mid_out_count", 128'(got_q.size()), 128'(1));
    if (got_q.size() > 0) chk("mid_ct", got_q[0], vt[0].ct);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 700; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_pt     = {$urandom, $urandom, $urandom, $urandom};
      in_key    = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 14; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
